// File: rtl/cia_bus_sequencer.sv
// 6800-style CIA bus sequencer: aligns CPU requests to the E clock phases,
// drives VMA and the E-high strobe, captures read data and returns a one-cycle ack.
module cia_bus_sequencer #(
    parameter int DW   = 8,
    parameter int WDOG = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    eclk,
    input  logic          req,
    input  logic          rw,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          ack,
    output logic          vma,
    output logic          cia_en,
    output logic          cia_we,
    output logic [DW-1:0] cia_dout,
    input  logic [DW-1:0] cia_din,
    output logic          eclk_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ACCESS,
        S_ACK,
        S_REL
    } state_t;

    state_t        state_q, state_d;
    logic          vma_q, vma_d;
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] cdout_q, cdout_d;
    logic [3:0]    wd_q, wd_d;
    logic          err_q, err_d;

    // Only phases 0, 3, 5 and 9 carry meaning for the sequencer.
    logic unused_eclk;
    assign unused_eclk = ^{eclk[8:6], eclk[4], eclk[2:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vma_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            dout_q  <= '0;
            cdout_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vma_q   <= vma_d;
            en_q    <= en_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            cdout_q <= cdout_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // Missing-E watchdog: saturating count of cycles since the last phase 0.
    always_comb begin
        wd_d = wd_q;
        if (eclk[0]) begin
            wd_d = '0;
        end else if (wd_q != '1) begin
            wd_d = wd_q + 4'd1;
        end
        err_d = err_q | (wd_d == 4'(WDOG));
    end

    always_comb begin
        state_d = state_q;
        vma_d   = vma_q;
        en_d    = en_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        dout_d  = dout_q;
        cdout_d = cdout_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (eclk[3]) begin
                        state_d = S_ACCESS;
                        vma_d   = 1'b1;
                        we_d    = ~rw;
                        cdout_d = din;
                    end else begin
                        state_d = S_SYNC;
                    end
                end
            end
            S_SYNC: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (eclk[3]) begin
                    state_d = S_ACCESS;
                    vma_d   = 1'b1;
                    we_d    = ~rw;
                    cdout_d = din;
                end else if (err_q) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    dout_d  = '1;
                end
            end
            S_ACCESS: begin
                if (eclk[5]) begin
                    en_d = 1'b1;
                end
                // Phase 9 closes the cycle even if a request drop was seen earlier.
                if (eclk[9]) begin
                    vma_d   = 1'b0;
                    en_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (!we_q) begin
                        dout_d = cia_din;
                    end
                end
            end
            S_ACK: begin
                state_d = req ? S_REL : S_IDLE;
            end
            S_REL: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dout     = dout_q;
    assign ack      = ack_q;
    assign vma      = vma_q;
    assign cia_en   = en_q;
    assign cia_we   = we_q;
    assign cia_dout = cdout_q;
    assign eclk_err = err_q;

endmodule

// File: tb/tb_cia_bus_sequencer.sv
// Self-checking bench for cia_bus_sequencer: randomized accesses checked against
// phase-arithmetic expectations and a cycle-count watchdog model.
module tb_cia_bus_sequencer;

    localparam int WDOG = 15;

    logic       clk;
    logic       reset;
    logic [9:0] eclk;
    logic       req;
    logic       rw;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ack;
    logic       vma;
    logic       cia_en;
    logic       cia_we;
    logic [7:0] cia_dout;
    logic [7:0] cia_din;
    logic       eclk_err;

    int         ph;
    bit         run;
    int         miss;
    bit         exp_err;
    logic [7:0] exp_dout;
    int         n_checks;
    int         n_err;

    cia_bus_sequencer #(
        .DW   (8),
        .WDOG (WDOG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .eclk     (eclk),
        .req      (req),
        .rw       (rw),
        .din      (din),
        .dout     (dout),
        .ack      (ack),
        .vma      (vma),
        .cia_en   (cia_en),
        .cia_we   (cia_we),
        .cia_dout (cia_dout),
        .cia_din  (cia_din),
        .eclk_err (eclk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t ph=%0d)", tag, got, exp, $time, ph);
        end
    endtask

    // Advance one clock; E phase generator and watchdog model update here.
    task automatic step();
        logic prev0;
        prev0 = eclk[0];
        @(posedge clk);
        if (reset || prev0) miss = 0;
        else miss++;
        if (reset) exp_err = 1'b0;
        else if (miss >= WDOG) exp_err = 1'b1;
        #1;
        if (run) begin
            ph   = (ph + 1) % 10;
            eclk = 10'(1) << ph;
        end else begin
            eclk = '0;
        end
        check_val("eclk_err", eclk_err, exp_err);
    endtask

    task automatic do_access(input int p, input bit rd, input logic [7:0] wdata,
                             input logic [7:0] rdata, input int hold, input bit drop7);
        int lat;
        bit in_vma;
        do begin
            step();
            check_val("idle_vma", vma, 1'b0);
            check_val("idle_ack", ack, 1'b0);
        end while (ph != p);
        req = 1'b1;
        rw  = rd;
        din = wdata;
        lat = (p <= 3) ? 10 - p : 20 - p;
        for (int k = 1; k <= lat; k++) begin
            step();
            in_vma  = (k >= lat - 6) && (k < lat);
            cia_din = (ph == 9) ? rdata : 8'($urandom);
            // Request-side fields may change once the access has latched them.
            if (in_vma) begin
                rw  = 1'($urandom);
                din = 8'($urandom);
            end
            if (drop7 && in_vma && ph == 7) req = 1'b0;
            if (k == lat && rd) exp_dout = rdata;
            check_val("vma", vma, in_vma);
            check_val("cia_en", cia_en, (k >= lat - 4) && (k < lat));
            check_val("ack", ack, k == lat);
            check_val("dout", dout, exp_dout);
            if (in_vma) begin
                check_val("cia_we", cia_we, !rd);
                check_val("cia_dout", cia_dout, wdata);
            end
        end
        if (!drop7) begin
            for (int h = 0; h < hold; h++) begin
                step();
                check_val("hold_vma", vma, 1'b0);
                check_val("hold_ack", ack, 1'b0);
            end
            req = 1'b0;
        end
    endtask

    task automatic abort_sync();
        do step(); while (ph != 5);
        req = 1'b1;
        rw  = 1'b1;
        do step(); while (ph != 8);
        req = 1'b0;
        repeat (25) begin
            step();
            check_val("abort_vma", vma, 1'b0);
            check_val("abort_ack", ack, 1'b0);
        end
    endtask

    task automatic reset_mid();
        do step(); while (ph != 2);
        req = 1'b1;
        rw  = 1'b1;
        din = 8'h3C;
        do step(); while (ph != 7);
        check_val("pre_rst_vma", vma, 1'b1);
        check_val("pre_rst_en", cia_en, 1'b1);
        reset = 1'b1;
        #1;
        check_val("rst_vma", vma, 1'b0);
        check_val("rst_en", cia_en, 1'b0);
        check_val("rst_ack", ack, 1'b0);
        check_val("rst_we", cia_we, 1'b0);
        check_val("rst_dout", dout, 8'h00);
        check_val("rst_cdout", cia_dout, 8'h00);
        exp_dout = 8'h00;
        req      = 1'b0;
        miss     = 0;
        repeat (3) step();
        check_val("rst_hold_ack", ack, 1'b0);
        reset = 1'b0;
        do_access(1, 1'b1, 8'h00, 8'h96, 0, 1'b0);
    endtask

    task automatic watchdog();
        int n;
        do step(); while (ph != 5);
        req = 1'b1;
        rw  = 1'b1;
        run = 1'b0;
        n   = 0;
        while (!eclk_err && n < 40) begin
            step();
            check_val("wd_wait_ack", ack, 1'b0);
            n++;
        end
        check_val("wd_raised", eclk_err, 1'b1);
        step();
        exp_dout = 8'hFF;
        check_val("wd_ack", ack, 1'b1);
        check_val("wd_dout", dout, exp_dout);
        req = 1'b0;
        step();
        check_val("wd_ack_end", ack, 1'b0);
        run = 1'b1;
        repeat (30) step();
        check_val("wd_sticky", eclk_err, 1'b1);
        reset = 1'b1;
        #1;
        check_val("wd_rst_clear", eclk_err, 1'b0);
        exp_err  = 1'b0;
        miss     = 0;
        exp_dout = 8'h00;
        repeat (2) step();
        reset = 1'b0;
        do_access(3, 1'b1, 8'h00, 8'hA7, 0, 1'b0);
    endtask

    initial begin
        int   p;
        int   hold;
        int   r;
        bit   rd;
        bit   d7;
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b1;
        req      = 1'b0;
        rw       = 1'b0;
        din      = 8'h00;
        cia_din  = 8'h00;
        ph       = 0;
        eclk     = 10'b1;
        run      = 1'b1;
        miss     = 0;
        exp_err  = 1'b0;
        exp_dout = 8'h00;

        repeat (3) step();
        check_val("reset_vma", vma, 1'b0);
        check_val("reset_en", cia_en, 1'b0);
        check_val("reset_we", cia_we, 1'b0);
        check_val("reset_ack", ack, 1'b0);
        check_val("reset_dout", dout, 8'h00);
        check_val("reset_cdout", cia_dout, 8'h00);
        reset = 1'b0;

        do_access(1, 1'b1, 8'h11, 8'h5A, 0, 1'b0);
        do_access(6, 1'b0, 8'hC3, 8'h00, 0, 1'b0);
        do_access(2, 1'b1, 8'h00, 8'h24, 40, 1'b0);
        do_access(2, 1'b0, 8'h81, 8'h00, 0, 1'b0);
        abort_sync();
        do_access(5, 1'b1, 8'h00, 8'h6E, 0, 1'b1);
        do_access(3, 1'b1, 8'h00, 8'hE1, 2, 1'b0);
        do_access(9, 1'b0, 8'h7F, 8'h00, 0, 1'b0);

        repeat (30) begin
            p    = $urandom_range(0, 9);
            rd   = 1'($urandom);
            r    = $urandom_range(0, 3);
            hold = (r == 3) ? 40 : $urandom_range(0, 4);
            d7   = ($urandom_range(0, 7) == 0);
            do_access(p, rd, 8'($urandom), 8'($urandom), hold, d7);
        end

        reset_mid();
        watchdog();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cia_bus_sequencer.md
# cia_bus_sequencer

Sequences 6800-style synchronous peripheral accesses (8520 CIA bus) against the E clock phase enables produced by the clock generator. Accepts a level request from the CPU-side bus controller and waits for the correct E phase. Drives VMA and the E-high data strobe, captures read data at the end of E high, and returns a one-cycle acknowledge. Sits between the CPU bus arbiter and the CIA instances in the 7 MHz `clk` domain.

## Interface
- `DW`, 8: data width of CPU and CIA data paths.
- `WDOG`, 15: number of consecutive `clk` cycles without `eclk[0]` that flags a missing E clock.

- `clk`  in  1  7.09 MHz system clock; all registers on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `eclk`  in  10  one-hot E phase enables; `eclk[n]` is high for the single `clk` cycle in which the E counter equals n; E is high during phases 6..9.
- `req`  in  1  access request, level, held by requester until `ack`.
- `rw`  in  1  1 = read, 0 = write; sampled when an access starts.
- `din`  in  DW  CPU write data; sampled when an access starts.
- `dout`  out  DW  read data register.
- `ack`  out  1  one-cycle completion pulse.
- `vma`  out  1  valid memory address to CIAs.
- `cia_en`  out  1  data strobe, high during E-high phases of an access.
- `cia_we`  out  1  write enable, valid while `vma`.
- `cia_dout`  out  DW  write data to CIAs, held while `vma`.
- `cia_din`  in  DW  read data from CIAs.
- `eclk_err`  out  1  sticky missing-E-clock flag.

## Operation
- States: IDLE, SYNC, ACCESS, ACK, REL.
- IDLE: if `req` and `eclk[3]` → ACCESS; else if `req` → SYNC.
- SYNC: if `!req` → IDLE (abort, no ack). Else if `eclk[3]` → ACCESS. Else if `eclk_err` → ACK with `dout` <= all ones.
- Entry to ACCESS: `vma`<=1, `cia_we`<=~`rw`, `cia_dout`<=`din`.
- ACCESS: `cia_en`<=1 on edge sampling `eclk[5]`. On edge sampling `eclk[9]`: `vma`<=0, `cia_en`<=0, `ack`<=1, and `dout`<=`cia_din` if read (`dout` unchanged on write); → ACK.
- ACCESS is never aborted; a `req` drop inside ACCESS still completes the cycle and pulses `ack`.
- ACK: `ack`<=0. → IDLE if `!req`, else → REL.
- REL: wait for `!req` → IDLE. This prevents a held request from starting a second access.
- Watchdog: 4-bit counter cleared on `eclk[0]`, incremented otherwise, saturating. Reaching `WDOG` sets `eclk_err`, which stays set until `reset`.
- `eclk` with multiple bits set: no detection. Each bit acts independently as above.

## Timing
- Reset values: state IDLE, `vma`=0, `cia_en`=0, `cia_we`=0, `ack`=0, `dout`=0, `cia_dout`=0, `eclk_err`=0, watchdog=0.
- All outputs are registered; none is combinational from inputs.
- Request first sampled in phase p, 0..3: `vma` high in phases 4..9 of the same E period, `cia_en` high in phases 6..9, `ack` high in phase 0 of the next period. Latency from sample to `ack` cycle = 10 − p cycles.
- Request first sampled in phase p, 4..9: the access runs in the next E period. Latency = 20 − p cycles.
- `vma` is exactly 6 cycles per access and `cia_en` exactly 4; `cia_we`/`cia_dout` are stable for the whole `vma` window.
- Back-to-back: `req` dropped during the ACK cycle and reasserted the next cycle starts a new access at the earliest in the following E period.
- Reset mid-access: all outputs return to reset values asynchronously. No `ack` is issued.

## Test plan
- Read, `req` raised in phase 1, `cia_din`=8'h5A → `vma` phases 4..9, `cia_en` phases 6..9, `cia_we`=0, `ack` in phase 0 nine cycles later, `dout`=8'h5A.
- Write, `req` raised in phase 6, `din`=8'hC3 → no `vma` until next period phase 4, `cia_we`=1, `cia_dout`=8'hC3 throughout, `ack` 14 cycles after sample.
- `req` held 40 cycles after `ack` → exactly one access. Drop and reraise → second access in the next available period.
- `req` raised in phase 5 and dropped in phase 8, then in a separate case dropped in phase 7 of ACCESS → first: no `vma`, no `ack`. Second: full 6-cycle `vma` and an `ack` pulse.
- Stop `eclk` entirely with `req` pending → `eclk_err`=1 after 15 cycles, `ack` pulse, `dout`=8'hFF. `eclk_err` remains 1 after `eclk` resumes until `reset`.
- Assert `reset` during phase 7 of an access → `vma`, `cia_en`, `ack` 0 immediately. After release, a new request completes normally.
